// File: rtl/axi_lite_master_if.sv
// AXI4-Lite channel bundle shared by initiators and targets.
// Master modport drives AW/W/AR payloads plus B/R readies.
interface axi4_lite_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0]   awaddr;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport m (
      output awaddr, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arprot, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready
   );

   modport s (
      input  awaddr, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arprot, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator behind a cmd/rsp port.
// Optional response watchdog: define AXI_MASTER_TIMEOUT_EN.
module axi_lite_master #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic            aclk,
   input  logic            areset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [DW-1:0]   cmd_wdata,
   input  logic [DW/8-1:0] cmd_wstrb,
   output logic            rsp_valid,
   output logic [DW-1:0]   rsp_rdata,
   output logic [1:0]      rsp_resp,
   axi4_lite_if.m          m
);

   localparam int SW = DW / 8;

   typedef enum logic [2:0] {
      IDLE,
      WADDR,
      WRESP,
      RADDR,
      RRESP
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic            aw_done_q, aw_done_d;
   logic            w_done_q, w_done_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]      rsp_resp_q, rsp_resp_d;

   logic accept;
   logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
   logic aw_all, w_all;
   logic tmo;

   assign cmd_ready = (state_q == IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Valids come from state only, never from the matching ready.
   assign m.awvalid = (state_q == WADDR) && !aw_done_q;
   assign m.wvalid  = (state_q == WADDR) && !w_done_q;
   assign m.bready  = (state_q == WADDR) || (state_q == WRESP);
   assign m.arvalid = (state_q == RADDR);
   assign m.rready  = (state_q == RADDR) || (state_q == RRESP);
   assign m.awaddr  = addr_q;
   assign m.araddr  = addr_q;
   assign m.awprot  = 3'b000;
   assign m.arprot  = 3'b000;
   assign m.wdata   = wdata_q;
   assign m.wstrb   = wstrb_q;

   assign aw_fire = m.awvalid && m.awready;
   assign w_fire  = m.wvalid && m.wready;
   assign b_fire  = m.bready && m.bvalid;
   assign ar_fire = m.arvalid && m.arready;
   assign r_fire  = m.rready && m.rvalid;
   assign aw_all  = aw_done_q || aw_fire;
   assign w_all   = w_done_q || w_fire;

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = '0;
      end else if (state_q != IDLE) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign tmo = (state_q != IDLE) && (cnt_d == CW'(TIMEOUT));

   always_ff @(posedge aclk) begin
      if (areset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d    = cmd_addr;
               wdata_d   = cmd_wdata;
               wstrb_d   = cmd_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = cmd_we ? WADDR : RADDR;
            end
         end
         WADDR: begin
            aw_done_d = aw_all;
            w_done_d  = w_all;
            if (aw_all && w_all) begin
               if (b_fire) begin
                  state_d     = IDLE;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = '0;
                  rsp_resp_d  = m.bresp;
               end else begin
                  state_d = WRESP;
               end
            end
         end
         WRESP: begin
            if (b_fire) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_resp_d  = m.bresp;
            end
         end
         RADDR: begin
            if (ar_fire) begin
               if (r_fire) begin
                  state_d     = IDLE;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = m.rdata;
                  rsp_resp_d  = m.rresp;
               end else begin
                  state_d = RRESP;
               end
            end
         end
         RRESP: begin
            if (r_fire) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = m.rdata;
               rsp_resp_d  = m.rresp;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A real response in the expiry cycle wins over the watchdog.
      if (tmo && !rsp_valid_d) begin
         state_d     = IDLE;
         rsp_valid_d = 1'b1;
         rsp_rdata_d = '0;
         rsp_resp_d  = 2'b11;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

endmodule
